m2_idct_block_scheduler: RTL and testbench
==========================================

// Module: m2_idct_block_scheduler
// PURPOSE
//  Top-level sequencer for the Milestone 2 IDCT datapath. Walks all 8x8 blocks (Y, then U, then V) and
//  issues start pulses to the four stage engines: Fetch S' (FS), Compute T (CT), Compute S (CS), Write S (WS).
//  Overlaps stages in two megastates, generates per-block SRAM base addresses and row strides, and selects
//  the SRAM port owner. Sits between the Milestone 2 top and the FS/CT/CS/WS engines.
// PARAMETERS
//  Y_COLS      40      Y blocks per block-row (image width/8)
//  UV_COLS     20      U/V blocks per block-row
//  ROWS        30      block-rows per plane
//  PRE_BASE    76800   SRAM base of pre-IDCT Y coefficients; U = PRE_BASE+Y_COLS*64*ROWS, V = U+UV_COLS*64*ROWS
//  POST_Y_BASE 0       SRAM base of output Y
//  POST_U_BASE 38400   SRAM base of output U
//  POST_V_BASE 57600   SRAM base of output V
// PORTS
//  Clock           in   1   system clock, all logic on rising edge
//  Reset           in   1   synchronous, active-high reset
//  Enable          in   1   one-cycle start of a full-image run; ignored unless in IDLE
//  fs_start        out  1   one-cycle pulse: fetch block at fs_base_addr
//  fs_done         in   1   one-cycle pulse from FS engine
//  fs_base_addr    out  18  SRAM word address of block's top-left coefficient
//  fs_row_stride   out  9   words between block rows: Y_COLS*8 (Y) or UV_COLS*8 (U/V)
//  ct_start/ct_done     out/in 1  Compute T handshake
//  cs_start/cs_done     out/in 1  Compute S handshake
//  ws_start        out  1   one-cycle pulse: write block at ws_base_addr
//  ws_done         in   1   one-cycle pulse from WS engine
//  ws_base_addr    out  18  SRAM word address of block's top-left output pixel pair
//  ws_row_stride   out  8   Y_COLS*4 (Y) or UV_COLS*4 (U/V)
//  sram_owner      out  1   0 = FS drives SRAM (read), 1 = WS drives SRAM (write)
//  blocks_written  out  12  count of blocks whose WS completed this run
//  busy            out  1   high in every state except IDLE
//  done            out  1   one-cycle pulse when last WS completes
// BEHAVIOUR
//  - Reset: state IDLE; all *_start, busy, done, sram_owner = 0; addresses/strides/blocks_written = 0;
//    fetch/write pointers (plane,row,col) = (Y,0,0); done latches cleared. Reset mid-run aborts immediately.
//  - States: IDLE -Enable-> LI_FS -> LI_CT -> MB -> MA -> MB ... ; MB after last fetch -> LO_WS -> DONE -> IDLE.
//    LI_FS: FS(0). LI_CT: CT(0). MB: CS(k) + FS(k+1) (FS omitted when k is last block). MA: CT(k) + WS(k-1).
//    LO_WS: WS(last). DONE: one cycle, done=1.
//  - Start pulses asserted exactly one cycle, the first cycle after entering a state; base/stride outputs
//    registered, valid on that cycle and held until the next start of the same engine.
//  - Per-engine done latch: cleared on its start pulse, set by its done pulse (set wins if same cycle).
//    State exits when all engines started in that state have latched done; next state entered next cycle.
//    Done pulses from engines not started in the current state are ignored.
//  - sram_owner = 1 in MA and LO_WS, else 0; changes only on state transition.
//  - Pointer order: col++; col wrap (Y_COLS-1 or UV_COLS-1) -> col=0,row++; row wrap (ROWS-1) -> row=0,plane++.
//    Fetch pointer advances on fs_done latch at exit; write pointer on ws_done latch at exit.
//  - Addresses: fs_base = plane_pre_base + row*8*fs_row_stride + col*8;
//    ws_base = plane_post_base + row*8*ws_row_stride + col*4. 18-bit unsigned, no overflow for legal params.
//  - blocks_written increments on each latched ws_done; held after DONE until next Enable.
//  - Enable while busy ignored; total blocks N = ROWS*(Y_COLS+2*UV_COLS) = 2400 at defaults.
// TESTING
//  1 Params Y_COLS=2,UV_COLS=1,ROWS=1, engines ack after 3 cycles, Enable -> fs_base 76800,76808,76928,76992;
//    ws_base 0,4,38400,57600; strides fs 16,16,8,8 / ws 8,8,4,4; done after 4 ws_done; blocks_written=4.
//  2 Same run -> start order FS0,CT0,{CS0,FS1},{CT1,WS0},...,CS3,WS3; sram_owner=1 only during MA/LO_WS.
//  3 Defaults: 41st fetch (Y row1,col0) -> fs_base 79360, ws_base 1280; last V block -> fs 229272, ws 76236.
//  4 In MB, cs_done 2 cycles before fs_done and reverse order -> exit only after second done, 1 cycle later.
//  5 Reset=1 for one cycle mid-MA -> next cycle IDLE, all starts 0, busy 0; new Enable restarts at 76800.
//  6 Enable pulsed while busy and stray ws_done in MB -> no effect on state, pointers or blocks_written.

Source files
------------

// File: rtl/m2_idct_block_scheduler.sv
// Sequencer for the Milestone 2 IDCT: walks every 8x8 block (Y, U, V), overlaps the
// fetch/compute/write engines in two megastates and hands each engine its block address.
module m2_idct_block_scheduler #(
  parameter int unsigned Y_COLS      = 40,
  parameter int unsigned UV_COLS     = 20,
  parameter int unsigned ROWS        = 30,
  parameter int unsigned PRE_BASE    = 76800,
  parameter int unsigned POST_Y_BASE = 0,
  parameter int unsigned POST_U_BASE = 38400,
  parameter int unsigned POST_V_BASE = 57600
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Enable,
  output logic        fs_start,
  input  logic        fs_done,
  output logic [17:0] fs_base_addr,
  output logic [8:0]  fs_row_stride,
  output logic        ct_start,
  input  logic        ct_done,
  output logic        cs_start,
  input  logic        cs_done,
  output logic        ws_start,
  input  logic        ws_done,
  output logic [17:0] ws_base_addr,
  output logic [7:0]  ws_row_stride,
  output logic        sram_owner,
  output logic [11:0] blocks_written,
  output logic        busy,
  output logic        done
);

  localparam int unsigned PreUBase = PRE_BASE + Y_COLS * 64 * ROWS;
  localparam int unsigned PreVBase = PreUBase + UV_COLS * 64 * ROWS;
  localparam int unsigned EngFs = 0;
  localparam int unsigned EngCt = 1;
  localparam int unsigned EngCs = 2;
  localparam int unsigned EngWs = 3;
  // Plane 3 marks a pointer that has walked past the last V block.
  localparam logic [1:0] PlaneEnd = 2'd3;

  typedef enum logic [2:0] {
    StIdle, StLiFs, StLiCt, StMb, StMa, StLoWs, StDone
  } state_e;

  typedef struct packed {
    logic [1:0] plane;
    logic [7:0] row;
    logic [7:0] col;
  } ptr_t;

  function automatic ptr_t ptr_next(ptr_t p);
    ptr_t        n;
    int unsigned cols;
    cols = (p.plane == 2'd0) ? Y_COLS : UV_COLS;
    n = p;
    if (32'(p.col) == cols - 1) begin
      n.col = '0;
      if (32'(p.row) == ROWS - 1) begin
        n.row   = '0;
        n.plane = p.plane + 2'd1;
      end else begin
        n.row = p.row + 8'd1;
      end
    end else begin
      n.col = p.col + 8'd1;
    end
    return n;
  endfunction

  function automatic logic [8:0] fs_stride_of(logic [1:0] plane);
    return (plane == 2'd0) ? 9'(Y_COLS * 8) : 9'(UV_COLS * 8);
  endfunction

  function automatic logic [7:0] ws_stride_of(logic [1:0] plane);
    return (plane == 2'd0) ? 8'(Y_COLS * 4) : 8'(UV_COLS * 4);
  endfunction

  function automatic logic [17:0] fs_addr_of(ptr_t p);
    int unsigned base;
    int unsigned addr;
    case (p.plane)
      2'd0:    base = PRE_BASE;
      2'd1:    base = PreUBase;
      default: base = PreVBase;
    endcase
    addr = base + 32'(p.row) * 32'd8 * 32'(fs_stride_of(p.plane)) + 32'(p.col) * 32'd8;
    return addr[17:0];
  endfunction

  function automatic logic [17:0] ws_addr_of(ptr_t p);
    int unsigned base;
    int unsigned addr;
    case (p.plane)
      2'd0:    base = POST_Y_BASE;
      2'd1:    base = POST_U_BASE;
      default: base = POST_V_BASE;
    endcase
    addr = base + 32'(p.row) * 32'd8 * 32'(ws_stride_of(p.plane)) + 32'(p.col) * 32'd4;
    return addr[17:0];
  endfunction

  state_e      state_q, state_d;
  ptr_t        fptr_q, fptr_d, wptr_q, wptr_d;
  logic [3:0]  act_q, act_d, dl_q, dl_d, start_q, start_d, start_set, eng_done;
  logic [17:0] fs_base_q, fs_base_d, ws_base_q, ws_base_d;
  logic [8:0]  fs_stride_q, fs_stride_d;
  logic [7:0]  ws_stride_q, ws_stride_d;
  logic [11:0] bw_q, bw_d;
  logic        all_done;

  assign eng_done = {ws_done, cs_done, ct_done, fs_done};
  // Engines not started in this state count as finished.
  assign all_done = &(~act_q | dl_q);

  always_comb begin
    state_d     = state_q;
    fptr_d      = fptr_q;
    wptr_d      = wptr_q;
    bw_d        = bw_q;
    act_d       = act_q;
    dl_d        = dl_q | (eng_done & act_q);
    start_d     = '0;
    start_set   = '0;
    fs_base_d   = fs_base_q;
    fs_stride_d = fs_stride_q;
    ws_base_d   = ws_base_q;
    ws_stride_d = ws_stride_q;

    unique case (state_q)
      StIdle: begin
        if (Enable) begin
          state_d = StLiFs;
          fptr_d  = '0;
          wptr_d  = '0;
          bw_d    = '0;
        end
      end
      StLiFs:  if (all_done) state_d = StLiCt;
      StLiCt:  if (all_done) state_d = StMb;
      StMb:    if (all_done) state_d = act_q[EngFs] ? StMa : StLoWs;
      StMa:    if (all_done) state_d = StMb;
      StLoWs:  if (all_done) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle && state_q != StDone && all_done) begin
      if (act_q[EngFs]) fptr_d = ptr_next(fptr_q);
      if (act_q[EngWs]) begin
        wptr_d = ptr_next(wptr_q);
        bw_d   = bw_q + 12'd1;
      end
    end

    if (state_d != state_q) begin
      dl_d = '0;
      case (state_d)
        StLiFs: start_set[EngFs] = 1'b1;
        StLiCt: start_set[EngCt] = 1'b1;
        StMb: begin
          start_set[EngCs] = 1'b1;
          start_set[EngFs] = (fptr_d.plane != PlaneEnd);
        end
        StMa: begin
          start_set[EngCt] = 1'b1;
          start_set[EngWs] = 1'b1;
        end
        StLoWs:  start_set[EngWs] = 1'b1;
        default: start_set = '0;
      endcase
      act_d   = start_set;
      start_d = start_set;
      if (start_set[EngFs]) begin
        fs_base_d   = fs_addr_of(fptr_d);
        fs_stride_d = fs_stride_of(fptr_d.plane);
      end
      if (start_set[EngWs]) begin
        ws_base_d   = ws_addr_of(wptr_d);
        ws_stride_d = ws_stride_of(wptr_d.plane);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= StIdle;
      fptr_q      <= '0;
      wptr_q      <= '0;
      bw_q        <= '0;
      act_q       <= '0;
      dl_q        <= '0;
      start_q     <= '0;
      fs_base_q   <= '0;
      fs_stride_q <= '0;
      ws_base_q   <= '0;
      ws_stride_q <= '0;
    end else begin
      state_q     <= state_d;
      fptr_q      <= fptr_d;
      wptr_q      <= wptr_d;
      bw_q        <= bw_d;
      act_q       <= act_d;
      dl_q        <= dl_d;
      start_q     <= start_d;
      fs_base_q   <= fs_base_d;
      fs_stride_q <= fs_stride_d;
      ws_base_q   <= ws_base_d;
      ws_stride_q <= ws_stride_d;
    end
  end

  assign fs_start       = start_q[EngFs];
  assign ct_start       = start_q[EngCt];
  assign cs_start       = start_q[EngCs];
  assign ws_start       = start_q[EngWs];
  assign fs_base_addr   = fs_base_q;
  assign fs_row_stride  = fs_stride_q;
  assign ws_base_addr   = ws_base_q;
  assign ws_row_stride  = ws_stride_q;
  assign blocks_written = bw_q;
  assign busy           = (state_q != StIdle);
  assign done           = (state_q == StDone);
  assign sram_owner     = (state_q == StMa) || (state_q == StLoWs);

endmodule

// File: tb/tb_m2_idct_block_scheduler.sv
// Directed bench: a 4-block image (2/1/1 block columns) under automatic and manual engine
// acks, plus a full default-size run for the far-end addresses.
module tb_m2_idct_block_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Small instance: bit 0 FS, 1 CT, 2 CS, 3 WS.
  logic        s_en;
  logic [3:0]  s_st, s_dn, s_auto, s_man;
  logic [17:0] s_fsb, s_wsb;
  logic [8:0]  s_fss;
  logic [7:0]  s_wss;
  logic        s_own, s_busy, s_donep;
  logic [11:0] s_bw;
  bit          s_auto_on = 1'b0;
  int          s_dly = 3;
  int          s_cnt[4];
  assign s_dn = s_auto | s_man;

  m2_idct_block_scheduler #(.Y_COLS(2), .UV_COLS(1), .ROWS(1)) u_small (
    .Clock(clk), .Reset(rst), .Enable(s_en),
    .fs_start(s_st[0]), .fs_done(s_dn[0]), .fs_base_addr(s_fsb), .fs_row_stride(s_fss),
    .ct_start(s_st[1]), .ct_done(s_dn[1]), .cs_start(s_st[2]), .cs_done(s_dn[2]),
    .ws_start(s_st[3]), .ws_done(s_dn[3]), .ws_base_addr(s_wsb), .ws_row_stride(s_wss),
    .sram_owner(s_own), .blocks_written(s_bw), .busy(s_busy), .done(s_donep)
  );

  // Default-size instance, always auto-acked one cycle after each start.
  logic        b_en;
  logic [3:0]  b_st, b_auto;
  logic [17:0] b_fsb, b_wsb;
  logic [8:0]  b_fss;
  logic [7:0]  b_wss;
  logic        b_own, b_busy, b_donep;
  logic [11:0] b_bw;
  int          b_cnt[4];

  m2_idct_block_scheduler u_big (
    .Clock(clk), .Reset(rst), .Enable(b_en),
    .fs_start(b_st[0]), .fs_done(b_auto[0]), .fs_base_addr(b_fsb), .fs_row_stride(b_fss),
    .ct_start(b_st[1]), .ct_done(b_auto[1]), .cs_start(b_st[2]), .cs_done(b_auto[2]),
    .ws_start(b_st[3]), .ws_done(b_auto[3]), .ws_base_addr(b_wsb), .ws_row_stride(b_wss),
    .sram_owner(b_own), .blocks_written(b_bw), .busy(b_busy), .done(b_donep)
  );

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      s_auto[i] = 1'b0;
      if (s_auto_on) begin
        if (s_cnt[i] == 1) s_auto[i] = 1'b1;
        if (s_cnt[i] != 0) s_cnt[i] = s_cnt[i] - 1;
        if (s_st[i] === 1'b1) s_cnt[i] = s_dly;
      end else begin
        s_cnt[i] = 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      b_auto[i] = 1'b0;
      if (b_cnt[i] == 1) b_auto[i] = 1'b1;
      if (b_cnt[i] != 0) b_cnt[i] = b_cnt[i] - 1;
      if (b_st[i] === 1'b1) b_cnt[i] = 1;
    end
  end

  // Leaves the caller 1ns after the edge that moved the DUT out of IDLE.
  task automatic pulse_enable_s();
    repeat (2) @(negedge clk);
    s_en = 1'b1;
    @(posedge clk);
    #1;
    s_en = 1'b0;
  endtask

  task automatic pulse_done(input int idx);
    @(negedge clk);
    s_man[idx] = 1'b1;
    @(negedge clk);
    s_man[idx] = 1'b0;
  endtask

  task automatic wait_start(input int idx, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (s_st[idx] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_en = 1'b0; b_en = 1'b0; s_man = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", s_busy); end
    checks++; if (s_st !== 4'b0) begin errors++; $display("FAIL reset_starts got %b want 0000", s_st); end
    checks++; if (s_own !== 1'b0) begin errors++; $display("FAIL reset_owner got %b want 0", s_own); end
    checks++; if (s_donep !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", s_donep); end
    checks++; if (s_bw !== 12'd0) begin errors++; $display("FAIL reset_bw got %0d want 0", s_bw); end
    checks++;
    if (s_fsb !== 18'd0 || s_wsb !== 18'd0 || s_fss !== 9'd0 || s_wss !== 8'd0) begin
      errors++; $display("FAIL reset_addr got %0d/%0d/%0d/%0d want 0", s_fsb, s_wsb, s_fss, s_wss);
    end
    checks++; if (b_busy !== 1'b0 || b_st !== 4'b0) begin
      errors++; $display("FAIL reset_big got busy=%b st=%b want 0", b_busy, b_st);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_small_run();
    logic [3:0]  ev[16];
    bit          own[16];
    logic [17:0] fb[8], wb[8];
    logic [8:0]  fst[8];
    logic [7:0]  wst[8];
    int          nev = 0, nf = 0, nw = 0;
    bit          got = 1'b0;
    logic [3:0]  exp_ev[10] = '{4'b0001, 4'b0010, 4'b0101, 4'b1010, 4'b0101,
                                4'b1010, 4'b0101, 4'b1010, 4'b0100, 4'b1000};
    bit          exp_own[10] = '{0, 0, 0, 1, 0, 1, 0, 1, 0, 1};
    int          exp_fb[4] = '{76800, 76808, 76928, 76992};
    int          exp_wb[4] = '{0, 4, 38400, 57600};
    int          exp_fs[4] = '{16, 16, 8, 8};
    int          exp_ws[4] = '{8, 8, 4, 4};
    s_auto_on = 1'b1;
    s_dly = 3;
    pulse_enable_s();
    for (int c = 0; c < 400; c++) begin
      if (s_st != 4'b0 && nev < 16) begin
        ev[nev] = s_st; own[nev] = s_own; nev++;
        if (s_st[0] && nf < 8) begin fb[nf] = s_fsb; fst[nf] = s_fss; nf++; end
        if (s_st[3] && nw < 8) begin wb[nw] = s_wsb; wst[nw] = s_wss; nw++; end
      end
      if (s_donep === 1'b1) begin got = 1'b1; break; end
      @(posedge clk);
      #1;
    end
    checks++; if (!got) begin errors++; $display("FAIL run_done got timeout want done pulse"); end
    checks++; if (nev != 10) begin errors++; $display("FAIL run_events got %0d want 10", nev); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (ev[i] !== exp_ev[i]) begin
        errors++; $display("FAIL run_order[%0d] got %b want %b", i, ev[i], exp_ev[i]);
      end
      checks++; if (own[i] !== exp_own[i]) begin
        errors++; $display("FAIL run_owner[%0d] got %b want %b", i, own[i], exp_own[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (fb[i] !== 18'(exp_fb[i]) || fst[i] !== 9'(exp_fs[i])) begin
        errors++;
        $display("FAIL run_fs[%0d] got %0d/%0d want %0d/%0d", i, fb[i], fst[i], exp_fb[i], exp_fs[i]);
      end
      checks++; if (wb[i] !== 18'(exp_wb[i]) || wst[i] !== 8'(exp_ws[i])) begin
        errors++;
        $display("FAIL run_ws[%0d] got %0d/%0d want %0d/%0d", i, wb[i], wst[i], exp_wb[i], exp_ws[i]);
      end
    end
    checks++; if (s_bw !== 12'd4) begin errors++; $display("FAIL run_bw got %0d want 4", s_bw); end
    @(posedge clk);
    #1;
    checks++; if (s_donep !== 1'b0 || s_busy !== 1'b0) begin
      errors++; $display("FAIL run_after got done=%b busy=%b want 0/0", s_donep, s_busy);
    end
    checks++; if (s_bw !== 12'd4) begin errors++; $display("FAIL run_bw_hold got %0d want 4", s_bw); end
  endtask

  task automatic test_mb_done_order();
    bit ok;
    s_auto_on = 1'b0;
    pulse_enable_s();
    wait_start(0, ok); pulse_done(0);
    wait_start(1, ok); pulse_done(1);
    wait_start(2, ok);
    checks++; if (!ok || s_st !== 4'b0101) begin
      errors++; $display("FAIL order_mb1_entry got %b want 0101", s_st);
    end
    pulse_done(2);
    checks++; if (s_st[1] !== 1'b0) begin errors++; $display("FAIL order_cs_first_early got 1 want 0"); end
    pulse_done(0);
    checks++; if (s_st[1] !== 1'b0) begin errors++; $display("FAIL order_fs_second_early got 1 want 0"); end
    @(posedge clk);
    #1;
    checks++; if (s_st !== 4'b1010 || s_wsb !== 18'd0 || s_own !== 1'b1) begin
      errors++; $display("FAIL order_ma1 got st=%b ws=%0d own=%b want 1010/0/1", s_st, s_wsb, s_own);
    end
    pulse_done(1); pulse_done(3);
    wait_start(2, ok);
    checks++; if (!ok || s_fsb !== 18'd76928) begin
      errors++; $display("FAIL order_mb2_fs got ok=%b fs=%0d want 1/76928", ok, s_fsb);
    end
    pulse_done(0);
    checks++; if (s_st[1] !== 1'b0) begin errors++; $display("FAIL order_fs_first_early got 1 want 0"); end
    pulse_done(2);
    checks++; if (s_st[1] !== 1'b0) begin errors++; $display("FAIL order_cs_second_early got 1 want 0"); end
    @(posedge clk);
    #1;
    checks++; if (s_st !== 4'b1010 || s_wsb !== 18'd4) begin
      errors++; $display("FAIL order_ma2 got st=%b ws=%0d want 1010/4", s_st, s_wsb);
    end
  endtask

  task automatic test_reset_mid_ma();
    bit ok;
    bit got = 1'b0;
    @(negedge clk);
    checks++; if (s_own !== 1'b1 || s_busy !== 1'b1) begin
      errors++; $display("FAIL midma_pre got own=%b busy=%b want 1/1", s_own, s_busy);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (s_busy !== 1'b0 || s_st !== 4'b0 || s_own !== 1'b0 || s_bw !== 12'd0) begin
      errors++;
      $display("FAIL midma_reset got busy=%b st=%b own=%b bw=%0d want 0", s_busy, s_st, s_own, s_bw);
    end
    s_auto_on = 1'b1;
    pulse_enable_s();
    wait_start(0, ok);
    checks++; if (!ok || s_fsb !== 18'd76800) begin
      errors++; $display("FAIL midma_restart got ok=%b fs=%0d want 1/76800", ok, s_fsb);
    end
    for (int c = 0; c < 400; c++) begin
      if (s_donep === 1'b1) begin got = 1'b1; break; end
      @(posedge clk);
      #1;
    end
    checks++; if (!got || s_bw !== 12'd4) begin
      errors++; $display("FAIL midma_rerun got done=%b bw=%0d want 1/4", got, s_bw);
    end
  endtask

  task automatic test_busy_ignore();
    bit ok;
    s_auto_on = 1'b0;
    pulse_enable_s();
    wait_start(0, ok); pulse_done(0);
    wait_start(1, ok); pulse_done(1);
    wait_start(2, ok);
    @(negedge clk);
    s_man[3] = 1'b1;
    s_en = 1'b1;
    @(negedge clk);
    s_man[3] = 1'b0;
    s_en = 1'b0;
    checks++; if (s_st !== 4'b0 || s_bw !== 12'd0) begin
      errors++; $display("FAIL ignore_stray got st=%b bw=%0d want 0000/0", s_st, s_bw);
    end
    pulse_done(2); pulse_done(0);
    @(posedge clk);
    #1;
    checks++; if (s_st !== 4'b1010 || s_wsb !== 18'd0 || s_bw !== 12'd0) begin
      errors++; $display("FAIL ignore_ma got st=%b ws=%0d bw=%0d want 1010/0/0", s_st, s_wsb, s_bw);
    end
    pulse_done(1); pulse_done(3);
    wait_start(2, ok);
    checks++; if (!ok || s_fsb !== 18'd76928 || s_bw !== 12'd1) begin
      errors++; $display("FAIL ignore_mb2 got fs=%0d bw=%0d want 76928/1", s_fsb, s_bw);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_defaults();
    int          nf = 0, nw = 0;
    logic [17:0] f41 = '0, w41 = '0, lastf = '0, lastw = '0;
    bit          got = 1'b0;
    repeat (2) @(negedge clk);
    b_en = 1'b1;
    @(posedge clk);
    #1;
    b_en = 1'b0;
    for (int c = 0; c < 40000; c++) begin
      if (b_st[0] === 1'b1) begin nf++; if (nf == 41) f41 = b_fsb; lastf = b_fsb; end
      if (b_st[3] === 1'b1) begin nw++; if (nw == 41) w41 = b_wsb; lastw = b_wsb; end
      if (b_donep === 1'b1) begin got = 1'b1; break; end
      @(posedge clk);
      #1;
    end
    checks++; if (!got) begin errors++; $display("FAIL big_done got timeout want done pulse"); end
    checks++; if (nf != 2400 || nw != 2400) begin
      errors++; $display("FAIL big_counts got fs=%0d ws=%0d want 2400/2400", nf, nw);
    end
    checks++; if (f41 !== 18'd79360 || w41 !== 18'd1280) begin
      errors++; $display("FAIL big_41st got fs=%0d ws=%0d want 79360/1280", f41, w41);
    end
    checks++; if (lastf !== 18'd229272 || lastw !== 18'd76236) begin
      errors++; $display("FAIL big_last got fs=%0d ws=%0d want 229272/76236", lastf, lastw);
    end
    checks++; if (b_fss !== 9'd160 || b_wss !== 8'd80) begin
      errors++; $display("FAIL big_stride got %0d/%0d want 160/80", b_fss, b_wss);
    end
    checks++; if (b_bw !== 12'd2400) begin errors++; $display("FAIL big_bw got %0d want 2400", b_bw); end
  endtask

  initial begin
    s_man = '0;
    test_reset();
    test_small_run();
    test_mb_done_order();
    test_reset_mid_ma();
    test_busy_ignore();
    test_defaults();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
